pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
// PURPOSE
//   Program-counter register and next-PC selector for the MIPS fetch path.
//   Consumes the word-aligned branch offset from the shift-left-2 stage (imm_shifted), adds it to PC+4,
//   and selects among sequential, branch, jump and jump-register targets.
//   Holds a redirect that arrives while fetch is stalled, so no redirect is ever lost.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC value loaded on reset; must be word aligned
// PORTS
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous, active-low reset
//   fetch_ready    in   1   instruction memory accepts the current pc
//   stall          in   1   hazard stall; blocks PC advance
//   resolve_valid  in   1   branch/jump fields below are valid this cycle
//   branch         in   1   instruction is beq/bne
//   branch_ne      in   1   1 = bne, 0 = beq
//   zero           in   1   ALU zero flag
//   jump           in   1   j/jal
//   jump_reg       in   1   jr
//   imm_shifted    in  32   sign-extended immediate << 2 (from shift-left-2 stage)
//   jump_index     in  26   instr[25:0]
//   reg_target     in  32   rs value for jr
//   pc             out 32   current fetch address
//   pc_plus4       out 32   pc + 4, mod 2^32
//   pc_valid       out  1   pc is presentable to instruction memory
//   redirect_taken out  1   1-cycle pulse: pc was loaded from a redirect target
//   misalign_err   out  1   1-cycle pulse: jr target had [1:0] != 0
// BEHAVIOUR
//   Reset (async, rst_n=0): pc=RESET_PC, pc_valid=0, redirect_taken=0, misalign_err=0,
//     pending target cleared, state=BOOT. Mid-operation reset discards any pending redirect.
//   States: BOOT -> RUN (unconditional, 1 cycle after reset release; pc_valid=1 from RUN on).
//     RUN -> HOLD on resolve_valid with a redirect and !fire. HOLD -> RUN on fire.
//   fire = pc_valid & fetch_ready & ~stall.
//   taken = branch & (zero ^ branch_ne). Redirect priority: jump_reg > jump > taken.
//   Targets (all mod 2^32): branch = pc_plus4 + imm_shifted;
//     jump = {pc_plus4[31:28], jump_index, 2'b00}; jr = {reg_target[31:2], 2'b00}.
//   jr with reg_target[1:0]!=0: misalign_err pulses the cycle after resolve; target uses cleared low bits.
//   RUN, fire, redirect     : pc <= target, redirect_taken=1 next cycle.
//   RUN, fire, no redirect  : pc <= pc_plus4 (0xFFFF_FFFC wraps to 0x0000_0000).
//   RUN, !fire, redirect    : pending <= target, -> HOLD; pc unchanged.
//   HOLD, fire              : pc <= pending, redirect_taken=1 next cycle, -> RUN.
//   HOLD, new redirect      : pending overwritten (latest wins); if same cycle fires, new target used.
//   resolve_valid with no redirect: sequential behaviour, pending untouched.
//   pc_plus4 is combinational from pc; all other outputs registered. Latency: 1 cycle fire->new pc.
// STRUCTURE
//   Shared package pc_pkg: state encoding (BOOT, RUN, HOLD), RESET_PC default, PC_INC=4.
//   Sub-module pc_target_calc (combinational): taken decode, priority mux, target adder, misalign flag.
//   Top: state register, pc register, pending register, output pulse registers.
// TESTING
//   Reset then release, fetch_ready=1: pc=0 with pc_valid=0 for 1 cycle, then 0,4,8,... per cycle.
//   beq, zero=1, pc=0x40, imm_shifted=0xFFFF_FFF0 -> pc=0x34 next cycle, redirect_taken=1.
//   bne, zero=1 -> no redirect, pc=pc+4; j at pc=0x1000_0010, jump_index=0x10 -> pc=0x1000_0040.
//   jr reg_target=0x203 with stall=1 for 3 cycles -> pc held, HOLD; on release pc=0x200, misalign_err pulsed once.
//   HOLD with pending 0x80, new jump to 0x100 arrives -> pc=0x100 on fire; 0x80 never appears.
//   pc=0xFFFF_FFFC sequential -> pc=0; assert rst_n=0 in HOLD -> pc=RESET_PC, pending dropped.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-path PC unit: state encoding and PC constants.
package pc_pkg;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect decode: branch condition, target priority mux and jr alignment check.
module pc_target_calc
  import pc_pkg::*;
(
  input  logic        resolve_valid,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] imm_shifted,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  output logic        redirect,
  output logic [31:0] target,
  output logic        misalign
);
  logic        taken;
  logic [31:0] br_target;

  assign taken     = branch & (zero ^ branch_ne);
  assign br_target = pc_plus4 + imm_shifted;

  always_comb begin
    redirect = 1'b0;
    target   = br_target;
    misalign = 1'b0;
    if (resolve_valid) begin
      // jr beats j beats a taken branch; a misaligned jr still redirects with low bits cleared
      if (jump_reg) begin
        redirect = 1'b1;
        target   = {reg_target[31:2], 2'b00};
        misalign = |reg_target[1:0];
      end else if (jump) begin
        redirect = 1'b1;
        target   = {pc_plus4[31:28], jump_index, 2'b00};
      end else if (taken) begin
        redirect = 1'b1;
        target   = br_target;
      end
    end
  end
endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register with next-PC selection; parks a redirect that arrives while fetch is blocked.
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        resolve_valid,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] imm_shifted,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        redirect_taken,
  output logic        misalign_err
);
  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        pc_valid_q, pc_valid_d;
  logic        redirect_taken_q, redirect_taken_d;
  logic        misalign_q, misalign_d;

  logic        fire;
  logic        redirect;
  logic [31:0] target;
  logic        misalign;

  assign pc_plus4 = pc_q + PC_INC;
  assign fire     = pc_valid_q & fetch_ready & ~stall;

  pc_target_calc u_calc (
    .resolve_valid (resolve_valid),
    .branch        (branch),
    .branch_ne     (branch_ne),
    .zero          (zero),
    .jump          (jump),
    .jump_reg      (jump_reg),
    .pc_plus4      (pc_plus4),
    .imm_shifted   (imm_shifted),
    .jump_index    (jump_index),
    .reg_target    (reg_target),
    .redirect      (redirect),
    .target        (target),
    .misalign      (misalign)
  );

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pending_d        = pending_q;
    pc_valid_d       = pc_valid_q;
    redirect_taken_d = 1'b0;
    misalign_d       = 1'b0;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        misalign_d = misalign;
        if (fire) begin
          pc_d             = redirect ? target : pc_plus4;
          redirect_taken_d = redirect;
        end else if (redirect) begin
          pending_d = target;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        misalign_d = misalign;
        // a redirect resolved in the firing cycle is newer than the parked one
        if (fire) begin
          pc_d             = redirect ? target : pending_q;
          redirect_taken_d = 1'b1;
          state_d          = RUN;
        end else if (redirect) begin
          pending_d = target;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= BOOT;
      pc_q             <= RESET_PC;
      pending_q        <= 32'h0;
      pc_valid_q       <= 1'b0;
      redirect_taken_q <= 1'b0;
      misalign_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pending_q        <= pending_d;
      pc_valid_q       <= pc_valid_d;
      redirect_taken_q <= redirect_taken_d;
      misalign_q       <= misalign_d;
    end
  end

  assign pc             = pc_q;
  assign pc_valid       = pc_valid_q;
  assign redirect_taken = redirect_taken_q;
  assign misalign_err   = misalign_q;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: sequential fetch, branches, jumps, stalled redirects, wrap, reset.
module tb_pc_branch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_ready, stall, resolve_valid;
  logic        branch, branch_ne, zero, jump, jump_reg;
  logic [31:0] imm_shifted, reg_target;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4;
  logic        pc_valid, redirect_taken, misalign_err;

  int n_checks = 0;
  int n_fails  = 0;

  pc_branch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_ready    (fetch_ready),
    .stall          (stall),
    .resolve_valid  (resolve_valid),
    .branch         (branch),
    .branch_ne      (branch_ne),
    .zero           (zero),
    .jump           (jump),
    .jump_reg       (jump_reg),
    .imm_shifted    (imm_shifted),
    .jump_index     (jump_index),
    .reg_target     (reg_target),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .pc_valid       (pc_valid),
    .redirect_taken (redirect_taken),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // pc, pc_valid, redirect_taken, misalign_err in one go
  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_v,
                         input logic e_rt, input logic e_me);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, e_v});
    chk({tag, ".redirect_taken"}, {31'b0, redirect_taken}, {31'b0, e_rt});
    chk({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, e_me});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    resolve_valid = 1'b0; branch = 1'b0; branch_ne = 1'b0; zero = 1'b0;
    jump = 1'b0; jump_reg = 1'b0; imm_shifted = '0; jump_index = '0; reg_target = '0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b1; stall = 1'b0;
    idle();
    #12;
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.pc_plus4", pc_plus4, 32'h4);

    // release away from the edge; BOOT lasts one cycle
    @(posedge clk); #1; rst_n = 1'b1;
    chk_all("boot", 32'h0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("run0", 32'h0, 1'b1, 1'b0, 1'b0);
    step(); chk_all("seq4", 32'h4, 1'b1, 1'b0, 1'b0);
    step(); chk_all("seq8", 32'h8, 1'b1, 1'b0, 1'b0);

    // j from pc=8: {0xC[31:28]=0, 0x10, 00} = 0x40
    resolve_valid = 1'b1; jump = 1'b1; jump_index = 26'h10;
    step(); idle(); chk_all("j_to_40", 32'h40, 1'b1, 1'b1, 1'b0);

    // beq taken: 0x44 + 0xFFFFFFF0 = 0x34
    resolve_valid = 1'b1; branch = 1'b1; zero = 1'b1; imm_shifted = 32'hFFFF_FFF0;
    step(); idle(); chk_all("beq_taken", 32'h34, 1'b1, 1'b1, 1'b0);

    // bne with zero=1 is not taken
    resolve_valid = 1'b1; branch = 1'b1; branch_ne = 1'b1; zero = 1'b1; imm_shifted = 32'h100;
    step(); idle(); chk_all("bne_not_taken", 32'h38, 1'b1, 1'b0, 1'b0);

    // jr and j together: jr wins
    resolve_valid = 1'b1; jump_reg = 1'b1; reg_target = 32'h1000_0010; jump = 1'b1; jump_index = 26'h3;
    step(); idle(); chk_all("jr_prio", 32'h1000_0010, 1'b1, 1'b1, 1'b0);

    // j keeps the upper nibble of pc+4
    resolve_valid = 1'b1; jump = 1'b1; jump_index = 26'h10; branch = 1'b1; zero = 1'b1;
    step(); idle(); chk_all("j_region", 32'h1000_0040, 1'b1, 1'b1, 1'b0);

    // misaligned jr under a 3-cycle stall
    stall = 1'b1; resolve_valid = 1'b1; jump_reg = 1'b1; reg_target = 32'h203;
    step(); idle(); chk_all("jr_stall1", 32'h1000_0040, 1'b1, 1'b0, 1'b1);
    step(); chk_all("jr_stall2", 32'h1000_0040, 1'b1, 1'b0, 1'b0);
    step(); chk_all("jr_stall3", 32'h1000_0040, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    step(); chk_all("jr_release", 32'h200, 1'b1, 1'b1, 1'b0);
    step(); chk_all("jr_after", 32'h204, 1'b1, 1'b0, 1'b0);

    // park 0x80, overwrite with 0x100 while still stalled
    stall = 1'b1; resolve_valid = 1'b1; jump = 1'b1; jump_index = 26'h20;
    step(); idle(); chk_all("hold_80", 32'h204, 1'b1, 1'b0, 1'b0);
    resolve_valid = 1'b1; jump = 1'b1; jump_index = 26'h40;
    step(); idle(); chk_all("hold_100", 32'h204, 1'b1, 1'b0, 1'b0);
    // non-redirecting resolve leaves the parked target alone
    resolve_valid = 1'b1; branch = 1'b1; zero = 1'b0;
    step(); idle(); chk_all("hold_keep", 32'h204, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    step(); chk_all("latest_wins", 32'h100, 1'b1, 1'b1, 1'b0);
    step(); chk_all("after_latest", 32'h104, 1'b1, 1'b0, 1'b0);

    // park 0x80, then a new jump resolves in the firing cycle
    stall = 1'b1; resolve_valid = 1'b1; jump = 1'b1; jump_index = 26'h20;
    step(); idle(); chk_all("hold_again", 32'h104, 1'b1, 1'b0, 1'b0);
    stall = 1'b0; resolve_valid = 1'b1; jump = 1'b1; jump_index = 26'h40;
    step(); idle(); chk_all("fire_new", 32'h100, 1'b1, 1'b1, 1'b0);

    // wrap at the top of the address space
    resolve_valid = 1'b1; jump_reg = 1'b1; reg_target = 32'hFFFF_FFFC;
    step(); idle(); chk_all("to_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    chk("top.pc_plus4", pc_plus4, 32'h0);
    step(); chk_all("wrap", 32'h0, 1'b1, 1'b0, 1'b0);
    step(); chk_all("wrap4", 32'h4, 1'b1, 1'b0, 1'b0);

    // reset while holding a parked redirect
    stall = 1'b1; resolve_valid = 1'b1; jump = 1'b1; jump_index = 26'h20;
    step(); idle(); chk_all("pre_rst_hold", 32'h4, 1'b1, 1'b0, 1'b0);
    #2; rst_n = 1'b0; #1;
    chk_all("mid_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    step(); rst_n = 1'b1;
    step(); chk_all("rst_run0", 32'h0, 1'b1, 1'b0, 1'b0);
    step(); chk_all("rst_dropped", 32'h4, 1'b1, 1'b0, 1'b0);
    step(); chk_all("rst_seq8", 32'h8, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
